// File: rtl/ecp5pll_phase_pkg.sv
// Shared types and helpers for the ECP5 PLL dynamic phase stepper.
package ecp5pll_phase_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    SETUP     = 3'd2,
    STEP      = 3'd3,
    LOAD      = 3'd4,
    SETTLE    = 3'd5,
    DONE      = 3'd6
  } state_e;

  // Output index as seen on the wrapper's clk_o vector
  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  // A zero-length phase would collapse the pulse timing, so never go below one cycle
  function automatic int unsigned clamp_min1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ecp5pll_phase_stepper_if.sv
// Request/status channel between a phase-calibration host and the phase stepper.
interface ecp5pll_phase_stepper_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_sel;
  logic             req_dir;
  logic [CNT_W-1:0] req_steps;
  logic             busy;
  logic             done;

  modport master (
    output req_valid, req_sel, req_dir, req_steps,
    input  req_ready, busy, done
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps,
    output req_ready, busy, done
  );
endinterface

// File: rtl/phase_step_timer.sv
// Loadable down-counter; expired_c is high once the loaded count has run out.
module phase_step_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk_i,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired_c
);

  logic [W-1:0] cnt_q;

  // Loading N-1 makes the owning state last exactly N cycles
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/ecp5pll_phase_stepper.sv
// ECP5 PLL dynamic phase sequencer: turns one step/reload request into timed PHASESTEP/PHASELOADREG pulses.
// Per-output position tracking (pos0..pos3) is built only with PHASE_STEPPER_POS_TRACK_EN defined.
module ecp5pll_phase_stepper
  import ecp5pll_phase_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 4,
  parameter int unsigned PULSE_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n,
  ecp5pll_phase_stepper_if.slave req,
  input  logic                   pll_locked,
  output logic [1:0]             phasesel,
  output logic                   phasedir,
  output logic                   phasestep,
  output logic                   phaseloadreg
`ifdef PHASE_STEPPER_POS_TRACK_EN
  ,
  output logic [CNT_W-1:0]       pos0,
  output logic [CNT_W-1:0]       pos1,
  output logic [CNT_W-1:0]       pos2,
  output logic [CNT_W-1:0]       pos3
`endif
);

  localparam int unsigned SETUP_N  = clamp_min1(SETUP_CYCLES);
  localparam int unsigned PULSE_N  = clamp_min1(PULSE_CYCLES);
  localparam int unsigned SETTLE_N = clamp_min1(SETTLE_CYCLES);
  localparam int unsigned MAX_N    = max3(SETUP_N, PULSE_N, SETTLE_N);
  localparam int unsigned TMR_W    = $clog2(MAX_N + 1);

  localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_N - 1);
  localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_N - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_N - 1);

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_WAIT_LOCK = WAIT_LOCK;
  localparam logic [2:0] S_SETUP     = SETUP;
  localparam logic [2:0] S_STEP      = STEP;
  localparam logic [2:0] S_LOAD      = LOAD;
  localparam logic [2:0] S_SETTLE    = SETTLE;
  localparam logic [2:0] S_DONE      = DONE;

  logic [2:0]       state_q, state_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic [1:0]       sel_q, sel_n;
  logic             dir_q, dir_n;
  logic             ready_q, ready_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             step_q, step_n;
  logic             load_q, load_n;

  logic             tmr_load_c;
  logic [TMR_W-1:0] tmr_val_c;
  logic             tmr_expired_c;
  logic             accept_c;

  assign accept_c = req.req_valid && ready_q;

  phase_step_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .load      (tmr_load_c),
    .load_val  (tmr_val_c),
    .expired_c (tmr_expired_c)
  );

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      sel_q   <= 2'd0;
      dir_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      sel_q   <= sel_n;
      dir_q   <= dir_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      step_q  <= step_n;
      load_q  <= load_n;
    end
  end

  // Next state; the timer is reloaded on every entry into a timed state
  always_comb begin
    state_n    = state_q;
    rem_n      = rem_q;
    sel_n      = sel_q;
    dir_n      = dir_q;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_n = S_WAIT_LOCK;
          sel_n   = req.req_sel;
          dir_n   = req.req_dir;
          rem_n   = CNT_W'(req.req_steps);
        end
      end
      S_WAIT_LOCK: begin
        if (pll_locked) begin
          state_n    = S_SETUP;
          tmr_load_c = 1'b1;
          tmr_val_c  = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (tmr_expired_c) begin
          // A zero-step request is the static reload
          state_n    = (rem_q != '0) ? S_STEP : S_LOAD;
          tmr_load_c = 1'b1;
          tmr_val_c  = PULSE_LD;
        end
      end
      S_STEP: begin
        if (tmr_expired_c) begin
          state_n    = S_SETTLE;
          rem_n      = rem_q - CNT_W'(1);
          tmr_load_c = 1'b1;
          tmr_val_c  = SETTLE_LD;
        end
      end
      S_LOAD: begin
        if (tmr_expired_c) begin
          state_n    = S_SETTLE;
          tmr_load_c = 1'b1;
          tmr_val_c  = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (tmr_expired_c) begin
          if (rem_q == '0) begin
            state_n = S_DONE;
          end else if (pll_locked) begin
            state_n    = S_SETUP;
            tmr_load_c = 1'b1;
            tmr_val_c  = SETUP_LD;
          end else begin
            state_n = S_WAIT_LOCK;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    ready_n = (state_n == S_IDLE);
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_DONE);
    step_n  = (state_n == S_STEP);
    load_n  = (state_n == S_LOAD);
  end

  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = load_q;
  assign req.req_ready = ready_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;

`ifdef PHASE_STEPPER_POS_TRACK_EN
  logic [CNT_W-1:0] pos_q [4];

  // Net step count per output; a static reload returns that output to its programmed phase
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        pos_q[i] <= '0;
      end
    end else if ((state_q == S_STEP) && tmr_expired_c) begin
      pos_q[sel_q] <= dir_q ? (pos_q[sel_q] + CNT_W'(1)) : (pos_q[sel_q] - CNT_W'(1));
    end else if ((state_q == S_LOAD) && tmr_expired_c) begin
      pos_q[sel_q] <= '0;
    end
  end

  assign pos0 = pos_q[SEL_CLKOP];
  assign pos1 = pos_q[SEL_CLKOS];
  assign pos2 = pos_q[SEL_CLKOS2];
  assign pos3 = pos_q[SEL_CLKOS3];
`endif

endmodule

// File: tb/tb_ecp5pll_phase_stepper.sv
// Directed bench for ecp5pll_phase_stepper: a timeline model predicts every output cycle by cycle.
module tb_ecp5pll_phase_stepper;
  import ecp5pll_phase_pkg::*;

  localparam int MAXC = 1024;
  localparam int S    = 4;
  localparam int P    = 4;
  localparam int T    = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic pll_locked;
  logic [1:0] phasesel;
  logic phasedir, phasestep, phaseloadreg;
`ifdef PHASE_STEPPER_POS_TRACK_EN
  logic [7:0] pos0, pos1, pos2, pos3;
`endif

  ecp5pll_phase_stepper_if #(.CNT_W(8)) rif ();

  ecp5pll_phase_stepper #(
    .SETUP_CYCLES (S),
    .PULSE_CYCLES (P),
    .SETTLE_CYCLES(T),
    .CNT_W        (8)
  ) dut (
    .clk_i       (clk),
    .reset_n     (reset_n),
    .req         (rif),
    .pll_locked  (pll_locked),
    .phasesel    (phasesel),
    .phasedir    (phasedir),
    .phasestep   (phasestep),
    .phaseloadreg(phaseloadreg)
`ifdef PHASE_STEPPER_POS_TRACK_EN
    ,
    .pos0        (pos0),
    .pos1        (pos1),
    .pos2        (pos2),
    .pos3        (pos3)
`endif
  );

  always #5 clk = ~clk;

  // cyc == n between posedge n and posedge n+1; inputs set then are sampled at edge n+1
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  bit       lock_arr  [MAXC];
  bit       exp_ready [MAXC];
  bit       exp_busy  [MAXC];
  bit       exp_done  [MAXC];
  bit       exp_step  [MAXC];
  bit       exp_load  [MAXC];
  bit [1:0] exp_sel   [MAXC];
  bit       exp_dir   [MAXC];

  bit       m_active = 1'b0;
  int       m_acc;
  bit [1:0] m_sel;
  bit       m_dir;
  int       m_steps;

  int  step_rises, step_high, load_rises, load_high;
  int  first_step, last_step, done_cyc;
  logic prev_step = 1'b0, prev_load = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int next_lock(input int from);
    for (int n = from; n < MAXC; n++) if (lock_arr[n]) return n;
    return -1;
  endfunction

  task automatic model_idle_from(input int r, input bit clear_sel);
    for (int n = r; n < MAXC; n++) begin
      exp_ready[n] = 1'b1;
      exp_busy[n]  = 1'b0;
      exp_done[n]  = 1'b0;
      exp_step[n]  = 1'b0;
      exp_load[n]  = 1'b0;
      if (clear_sel) begin
        exp_sel[n] = 2'd0;
        exp_dir[n] = 1'b0;
      end
    end
  endtask

  // Rebuild the whole expected timeline of the current request from its acceptance edge
  task automatic model_run();
    int e, f, last, npulse;
    if (!m_active) return;
    model_idle_from(m_acc, 1'b0);
    for (int n = m_acc; n < MAXC; n++) begin
      exp_sel[n] = m_sel;
      exp_dir[n] = m_dir;
    end
    npulse = (m_steps == 0) ? 1 : m_steps;
    last   = -1;
    e      = next_lock(m_acc + 1);
    for (int i = 0; i < npulse && e >= 0; i++) begin
      for (int n = e + S; n < e + S + P && n < MAXC; n++) begin
        if (m_steps == 0) exp_load[n] = 1'b1;
        else              exp_step[n] = 1'b1;
      end
      f = e + S + P + T;
      if (i == npulse - 1) last = f;
      else e = next_lock(f);
    end
    for (int n = m_acc; n < MAXC && (last < 0 || n <= last); n++) begin
      exp_busy[n]  = 1'b1;
      exp_ready[n] = 1'b0;
    end
    if (last >= 0 && last < MAXC) exp_done[last] = 1'b1;
  endtask

  task automatic tick();
    logic [7:0] got, want;
    @(negedge clk);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: cyc %0d exceeds limit %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (chk_en) begin
      got  = {rif.req_ready, rif.busy, rif.done, phasestep, phaseloadreg, phasesel, phasedir};
      want = {exp_ready[cyc], exp_busy[cyc], exp_done[cyc], exp_step[cyc], exp_load[cyc],
              exp_sel[cyc], exp_dir[cyc]};
      n_checks++;
      if (got !== want) begin
        n_errs++;
        $display("FAIL outputs{rdy,busy,done,step,load,sel,dir} cyc %0d: got %b expected %b",
                 cyc, got, want);
      end
    end
    if (phasestep === 1'b1) begin
      step_high++;
      if (prev_step !== 1'b1) begin
        step_rises++;
        last_step = cyc;
        if (first_step < 0) first_step = cyc;
      end
    end
    if (phaseloadreg === 1'b1) begin
      load_high++;
      if (prev_load !== 1'b1) load_rises++;
    end
    if (rif.done === 1'b1) done_cyc = cyc;
    prev_step = phasestep;
    prev_load = phaseloadreg;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_lock(input bit v);
    pll_locked = v;
    for (int n = cyc + 1; n < MAXC; n++) lock_arr[n] = v;
    model_run();
  endtask

  task automatic request(input bit [1:0] sel, input bit dir, input int steps);
    rif.req_valid = 1'b1;
    rif.req_sel   = sel;
    rif.req_dir   = dir;
    rif.req_steps = 8'(steps);
    m_acc   = cyc + 1;
    m_sel   = sel;
    m_dir   = dir;
    m_steps = steps;
    m_active = 1'b1;
    model_run();
    step_rises = 0; step_high = 0; load_rises = 0; load_high = 0;
    first_step = -1; last_step = -1; done_cyc = -1;
    tick();
    rif.req_valid = 1'b0;
  endtask

  initial begin
    int a, l;
    reset_n       = 1'b0;
    pll_locked    = 1'b1;
    rif.req_valid = 1'b0;
    rif.req_sel   = 2'd0;
    rif.req_dir   = 1'b0;
    rif.req_steps = 8'd0;
    for (int n = 0; n < MAXC; n++) lock_arr[n] = 1'b1;
    model_idle_from(0, 1'b1);

    // Reset state
    ticks(3);
    chk_en = 1'b1;
    chk("reset_ready", int'(rif.req_ready), 1);
    chk("reset_outs", int'({rif.busy, rif.done, phasestep, phaseloadreg, phasesel, phasedir}), 0);
    reset_n = 1'b1;
    ticks(2);

    // Three advance steps on CLKOS with lock held
    request(SEL_CLKOS, 1'b1, 3);
    a = m_acc;
    ticks(78);
    chk("t1_step_pulses", step_rises, 3);
    chk("t1_step_high", step_high, 12);
    chk("t1_load_pulses", load_rises, 0);
    chk("t1_done_latency", done_cyc - a, 73);
    chk("t1_sel_hold", int'(phasesel), 1);
    chk("t1_dir_hold", int'(phasedir), 1);
`ifdef PHASE_STEPPER_POS_TRACK_EN
    chk("t1_pos1", int'(pos1), 3);
`endif

    // Static reload on CLKOS2
    request(SEL_CLKOS2, 1'b0, 0);
    a = m_acc;
    ticks(30);
    chk("t2_load_pulses", load_rises, 1);
    chk("t2_load_high", load_high, 4);
    chk("t2_step_pulses", step_rises, 0);
    chk("t2_done_latency", done_cyc - a, 25);
`ifdef PHASE_STEPPER_POS_TRACK_EN
    chk("t2_pos2", int'(pos2), 0);
`endif

    // Accept while unlocked; lock arrives 50 cycles later
    set_lock(1'b0);
    tick();
    request(SEL_CLKOS3, 1'b1, 1);
    ticks(50);
    chk("t3_no_pulse_unlocked", step_rises + load_rises, 0);
    chk("t3_busy_waiting", int'(rif.busy), 1);
    set_lock(1'b1);
    l = cyc + 1;
    ticks(30);
    chk("t3_step_after_lock", first_step - l, 4);
    chk("t3_step_high", step_high, 4);
    chk("t3_done_after_lock", done_cyc - l, 24);

    // Lock lost mid-pulse during a two-step request
    request(SEL_CLKOP, 1'b1, 2);
    a = m_acc;
    ticks(6);
    set_lock(1'b0);
    ticks(34);
    chk("t4_first_pulse_count", step_rises, 1);
    chk("t4_first_pulse_width", step_high, 4);
    set_lock(1'b1);
    l = cyc + 1;
    ticks(30);
    chk("t4_step_pulses", step_rises, 2);
    chk("t4_step_high", step_high, 8);
    chk("t4_second_after_lock", last_step - l, 4);
    chk("t4_done_latency", done_cyc - a, 65);

    // Clear CLKOP position, then one retard step wraps it; requests while busy are dropped
    request(SEL_CLKOP, 1'b1, 0);
    ticks(30);
    chk("t5_reload_pulses", load_rises, 1);
`ifdef PHASE_STEPPER_POS_TRACK_EN
    chk("t5_pos0_cleared", int'(pos0), 0);
`endif
    request(SEL_CLKOP, 1'b0, 1);
    a = m_acc;
    ticks(3);
    rif.req_valid = 1'b1;
    rif.req_sel   = SEL_CLKOS3;
    rif.req_dir   = 1'b1;
    rif.req_steps = 8'd5;
    ticks(8);
    rif.req_valid = 1'b0;
    ticks(20);
    chk("t5_step_pulses", step_rises, 1);
    chk("t5_done_latency", done_cyc - a, 25);
    chk("t5_sel_kept", int'(phasesel), 0);
    chk("t5_dir_kept", int'(phasedir), 0);
`ifdef PHASE_STEPPER_POS_TRACK_EN
    chk("t5_pos0_wrap", int'(pos0), 255);
`endif

    // Reset in the middle of a step pulse
    request(SEL_CLKOS, 1'b1, 2);
    ticks(6);
    chk("t6_in_step", int'(phasestep), 1);
    reset_n  = 1'b0;
    m_active = 1'b0;
    model_idle_from(cyc + 1, 1'b1);
    tick();
    chk("t6_rst_step", int'(phasestep), 0);
    chk("t6_rst_ready", int'(rif.req_ready), 1);
    chk("t6_rst_busy", int'(rif.busy), 0);
    reset_n = 1'b1;
    ticks(2);
`ifdef PHASE_STEPPER_POS_TRACK_EN
    chk("t6_pos1_reset", int'(pos1), 0);
`endif
    request(SEL_CLKOS2, 1'b1, 1);
    a = m_acc;
    ticks(30);
    chk("t6_recover_pulses", step_rises, 1);
    chk("t6_recover_latency", done_cyc - a, 25);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ecp5pll_phase_stepper.md
Name: ecp5pll_phase_stepper

Overview:
- Sequencer directly downstream of the ECP5 PLL wrapper; drives its dynamic phase inputs (phasesel, phasedir, phasestep, phaseloadreg) and monitors its locked output.
- Converts one request ("shift output N by K steps, direction D", or "reload static phase") into correctly timed PHASESTEP/PHASELOADREG pulses.
- Tracks the net step position of each output.
- Used by SDRAM clock-phase calibration in the memtest firmware.

Parameters:
- SETUP_CYCLES, 4: cycles phasesel/phasedir are held stable before a pulse asserts; value 0 is treated as 1.
- PULSE_CYCLES, 4: high width of each phasestep/phaseloadreg pulse; value 0 is treated as 1.
- SETTLE_CYCLES, 16: idle cycles after each pulse falls; value 0 is treated as 1.
- CNT_W, 8: width of the step count and of each position register.

Ports:
- clk_i  in  1  system clock; the same domain as the wrapper's phase-control inputs.
- reset_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  high in IDLE; a request is accepted on req_valid&&req_ready.
- req_sel  in  2  output index 0..3, matching the clk_o index (the wrapper subtracts 1 internally).
- req_dir  in  1  1 = advance (phase increase), 0 = retard.
- req_steps  in  CNT_W  number of steps; 0 = static phase reload.
- pll_locked  in  1  wrapper's locked output.
- phasesel  out  2  to wrapper.
- phasedir  out  1  to wrapper.
- phasestep  out  1  to wrapper.
- phaseloadreg  out  1  to wrapper.
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle pulse when a request completes.
- pos0, pos1, pos2, pos3  out  CNT_W each  net step position per output (present only with the optional feature).

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State → IDLE.
  - All outputs 0 except req_ready=1.
  - Positions, timers and step counter cleared.
  - Reset mid-operation aborts immediately; no pulse is truncated to a glitch, because outputs are registered and cleared the same edge.
- Acceptance:
  - req_sel, req_dir and req_steps are captured into registers.
  - phasesel/phasedir are driven from those registers from the cycle after acceptance.
  - Both stay constant until done, and hold their last value afterwards.
- States and transitions:
  - IDLE: req_ready=1. On accept → WAIT_LOCK.
  - WAIT_LOCK: stays until pll_locked=1, then → SETUP with timer=SETUP_CYCLES.
  - SETUP: counts down.
    - On expiry with remaining>0 → STEP.
    - On expiry with req_steps==0 → LOAD.
  - STEP: phasestep=1 for PULSE_CYCLES; remaining decrements on exit → SETTLE.
  - LOAD: phaseloadreg=1 for PULSE_CYCLES → SETTLE.
  - SETTLE: counts down SETTLE_CYCLES, then:
    - remaining>0 and pll_locked → SETUP;
    - remaining>0 and !pll_locked → WAIT_LOCK;
    - otherwise → DONE.
  - DONE: done=1 for one cycle, busy=0 on the next cycle → IDLE.
- Latency of a K-step request with lock held: 1 + K*(SETUP+PULSE+SETTLE) cycles from acceptance to the done pulse.
  - Default values give 1 + 24K.
  - req_steps=0 gives 25.
- Lock handling:
  - Loss of lock during STEP, LOAD or SETTLE never shortens a pulse.
  - It only inserts WAIT_LOCK before the next SETUP.
- Handshake:
  - req_valid while busy is ignored; it is not queued.
  - req_ready and done are never high in the same cycle.
- Arithmetic: step and position counters are unsigned CNT_W bits and wrap modulo 2^CNT_W.

Optional Feature:
- Macro: PHASE_STEPPER_POS_TRACK_EN.
- Defined:
  - pos0..pos3 ports exist.
  - On each STEP exit, pos[sel] is incremented (dir=1) or decremented (dir=0), with wrap.
  - A LOAD clears pos[sel] to 0.
- Undefined:
  - pos ports and registers are absent.
  - All other behaviour is identical.

Decomposition:
- Package ecp5pll_phase_pkg holds:
  - state enum (IDLE, WAIT_LOCK, SETUP, STEP, LOAD, SETTLE, DONE);
  - output index constants SEL_CLKOP=0, SEL_CLKOS=1, SEL_CLKOS2=2, SEL_CLKOS3=3;
  - the min-1 clamp function for timing parameters.
- One natural sub-module: phase_step_timer.
  - Loadable down-counter with an expiry flag.
  - Width is the clog2 of max(SETUP,PULSE,SETTLE)+1.
  - Instantiated once and reloaded per state.

Test Plan:
- Reset, then request sel=1, dir=1, steps=3, with lock held:
  - exactly 3 phasestep pulses, each 4 cycles wide;
  - phasesel=1 and phasedir=1 throughout;
  - done at cycle 73 after acceptance;
  - pos1=3.
- Request sel=2, steps=0:
  - one 4-cycle phaseloadreg pulse and no phasestep;
  - done at cycle 25;
  - pos2=0.
- pll_locked=0 at acceptance and raised 50 cycles later:
  - no pulse before lock;
  - first phasestep begins 4 cycles after lock rises.
- Lock dropped mid-pulse during a 2-step request:
  - current pulse completes at full width;
  - second pulse waits for lock to return, then SETUP+PULSE.
- Wrap and guards:
  - sel=0, dir=0, steps=1 from pos0=0 gives pos0=255;
  - req_valid during busy is ignored (pulse count unchanged);
  - reset_n low mid-STEP zeroes phasestep at the next edge and restores req_ready=1.
